player_motion_control: RTL and testbench
========================================

# player_motion_control

Parametrised player state block for the raycaster. It turns held rotate and move buttons into rate-limited updates of the player's angle index and fixed-point position. Before any move is accepted it checks the map for walls through a one-cycle-latency map port, and slides along a wall when the full move is blocked. It sits between the debounced key inputs and the ray-cast engine, which consumes `playerX`, `playerY` and `angle`, and feeds back the direction vector `dir_x`/`dir_y` from its trig table.

## Interface
Parameters:
- `TICK_DIV`, 5_000_000 — clocks per update tick (10 Hz at 50 MHz); must be ≥ 8
- `POS_W`, 13 — signed position width
- `DIR_W`, 10 — signed direction-vector width
- `DIR_SHIFT`, 3 — arithmetic right shift applied to `dir_x`/`dir_y` to form the step
- `ANGLE_STEPS`, 320 — angle indices per full turn (1.125° each)
- `ANGLE_W`, 9 — angle index width; must satisfy 2^ANGLE_W ≥ ANGLE_STEPS
- `CELL_BITS`, 6 — log2 of map cell size in position units
- `POS_MAX`, 4095 — upper position clamp, inclusive
- `START_X`, 96; `START_Y`, 96; `START_ANGLE`, 80 — reset values

Ports (one clock; reset is asynchronous and active-high):
- `clock` in 1 — system clock
- `reset` in 1 — asynchronous, active-high
- `rotate_left` in 1 — held request to increment the angle
- `rotate_right` in 1 — held request to decrement the angle
- `move_forward` in 1 — held request to step along the direction vector
- `move_backward` in 1 — held request to step against the direction vector
- `dir_x`, `dir_y` in DIR_W signed — direction vector for the current `angle`
- `map_rd` out 1 — map read strobe
- `map_x`, `map_y` out POS_W-CELL_BITS — cell address, valid while `map_rd`=1
- `map_wall` in 1 — cell occupancy; valid the cycle after `map_rd`
- `playerX`, `playerY` out POS_W signed — position
- `angle` out ANGLE_W — angle index, 0..ANGLE_STEPS-1
- `busy` out 1 — high while a collision check is in progress
- `update` out 1 — one-cycle pulse after position or angle changes

## Operation
- Tick counter runs 0..TICK_DIV-1 and wraps. `tick`=1 when the count equals TICK_DIV-1.
- States:
  - S_IDLE: waits for a tick.
  - S_QUERY: `map_rd`=1; `map_x`/`map_y` = candidate >> CELL_BITS.
  - S_CHECK: samples `map_wall`.
- Behaviour on a tick in S_IDLE:
  - Rotation: `rotate_left` alone → angle+1, wrapping from ANGLE_STEPS-1 to 0. `rotate_right` alone → angle-1, wrapping from 0 to ANGLE_STEPS-1. Both or neither → no change.
  - Movement: `move_forward` alone → sign +1; `move_backward` alone → sign -1; both or neither → no move.
  - Step: dx = sign·(`dir_x` >>> DIR_SHIFT) and dy = sign·(`dir_y` >>> DIR_SHIFT), both sign-extended. `dir_x`/`dir_y` are sampled on the tick cycle, i.e. the pre-rotation direction.
  - Candidate sums are computed at POS_W+1 bits, then clamped: a negative sum becomes 0, a sum above POS_MAX becomes POS_MAX.
  - On a move, three candidates are tried in order: C0=(x+dx, y+dy), C1=(x+dx, y), C2=(x, y+dy). The FSM enters S_QUERY with C0.
- S_QUERY always goes to S_CHECK.
- S_CHECK:
  - `map_wall`=0 → commit the current candidate to `playerX`/`playerY` and go to S_IDLE.
  - `map_wall`=1 → go to S_QUERY with the next candidate. If C2 is blocked, go to S_IDLE with position unchanged.
  - A candidate equal to the current position in both axes (dx or dy = 0) is skipped without a query.
- A tick that occurs while not in S_IDLE is dropped; the tick counter keeps running.
- `busy` = (state ≠ S_IDLE).
- `update` pulses the cycle after an angle change or a position commit. A blocked move with no rotation produces no pulse.
- Reset, including mid-check:
  - Outputs: `playerX`=START_X, `playerY`=START_Y, `angle`=START_ANGLE, `map_rd`=0, `map_x`=0, `map_y`=0, `busy`=0, `update`=0.
  - Internals: tick counter = 0, state = S_IDLE.
  - Any in-flight candidate is discarded.

## Timing
- Tick cycle T, clock edge at the end of T: `angle` updates and, on a move, the state becomes S_QUERY. `update` is high in T+1 for a rotation.
- First query: `map_rd` high in T+1; `map_wall` sampled in T+2.
- Position commit on C0: position registers change at the end of T+2, are visible in T+3, and `update`=1 in T+3.
- Each fallback candidate adds 2 cycles. Worst case: `busy` high in T+1..T+6.
- With TICK_DIV ≥ 8, no tick is lost to `busy` in normal operation.
- `map_rd` is never high on two consecutive cycles.

## Test plan
- Reset with TICK_DIV=8 → pos (96,96), angle 80, `update`=0. Hold `rotate_left` for 3 ticks → angle 81, 82, 83, with one `update` pulse per tick.
- Angle wrap: angle 0 with `rotate_right` → 319. Angle 319 with `rotate_left` → 0. Both buttons held → no change and no `update`.
- Forward move on an open map, `dir_x`=80, `dir_y`=-40 → exactly one query at cell (1,1), then pos (106,91) visible 3 cycles after the tick.
- Wall slide: C0 blocked, C1 clear → two queries, pos (106,96). All three candidates blocked → pos unchanged, no `update`, `busy` high for 6 cycles.
- Clamp: pos (2,4090), `move_backward`, `dir_x`=80, `dir_y`=-80 → candidate (0,4095), committed when clear.
- Assert `reset` during S_CHECK → outputs return to reset values within the same cycle (asynchronously), and the next tick proceeds normally.

Source files
------------

// File: rtl/player_motion_control.sv
// Player state block: turns held buttons into tick-rate angle/position updates,
// checks candidate positions against the map and slides along walls.
module player_motion_control #(
  parameter int TICK_DIV    = 5_000_000,
  parameter int POS_W       = 13,
  parameter int DIR_W       = 10,
  parameter int DIR_SHIFT   = 3,
  parameter int ANGLE_STEPS = 320,
  parameter int ANGLE_W     = 9,
  parameter int CELL_BITS   = 6,
  parameter int POS_MAX     = 4095,
  parameter int START_X     = 96,
  parameter int START_Y     = 96,
  parameter int START_ANGLE = 80
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          rotate_left,
  input  logic                          rotate_right,
  input  logic                          move_forward,
  input  logic                          move_backward,
  input  logic signed [DIR_W-1:0]       dir_x,
  input  logic signed [DIR_W-1:0]       dir_y,
  output logic                          map_rd,
  output logic [POS_W-CELL_BITS-1:0]    map_x,
  output logic [POS_W-CELL_BITS-1:0]    map_y,
  input  logic                          map_wall,
  output logic signed [POS_W-1:0]       playerX,
  output logic signed [POS_W-1:0]       playerY,
  output logic [ANGLE_W-1:0]            angle,
  output logic                          busy,
  output logic                          update
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SUM_W = POS_W + 1;
  localparam logic [CNT_W-1:0]         CNT_LAST  = CNT_W'(TICK_DIV - 1);
  localparam logic [ANGLE_W-1:0]       ANG_LAST  = ANGLE_W'(ANGLE_STEPS - 1);
  localparam logic signed [SUM_W-1:0]  POS_MAX_S = SUM_W'(POS_MAX);

  typedef enum logic [1:0] {S_IDLE, S_QUERY, S_CHECK} state_t;

  state_t state, state_nx;

  logic [CNT_W-1:0] cnt;
  logic             tick;

  logic rot_l, rot_r, fwd, bwd, moving;
  logic signed [DIR_W-1:0] shx, shy;
  logic signed [SUM_W-1:0] stx, sty;
  logic signed [POS_W-1:0] c0x, c0y;
  logic [2:0]              try_mask;

  logic signed [POS_W-1:0] cand_x [3];
  logic signed [POS_W-1:0] cand_y [3];
  logic [2:0]              pend;
  logic [1:0]              sel, cur;

  function automatic logic signed [POS_W-1:0] clamp(input logic signed [SUM_W-1:0] s);
    if (s < 0)              return '0;
    else if (s > POS_MAX_S) return POS_W'(POS_MAX);
    else                    return s[POS_W-1:0];
  endfunction

  // free-running update tick
  always_ff @(posedge clock or posedge reset) begin
    if (reset)             cnt <= '0;
    else if (cnt == CNT_LAST) cnt <= '0;
    else                   cnt <= cnt + 1'b1;
  end
  assign tick = (cnt == CNT_LAST);

  assign rot_l  = rotate_left & ~rotate_right;
  assign rot_r  = rotate_right & ~rotate_left;
  assign fwd    = move_forward & ~move_backward;
  assign bwd    = move_backward & ~move_forward;
  assign moving = fwd | bwd;

  // step and the full-move candidate; C1/C2 reuse one axis of it
  always_comb begin
    shx = dir_x >>> DIR_SHIFT;
    shy = dir_y >>> DIR_SHIFT;
    stx = SUM_W'(shx);
    sty = SUM_W'(shy);
    if (bwd) begin
      stx = -stx;
      sty = -sty;
    end
    c0x = clamp(SUM_W'(playerX) + stx);
    c0y = clamp(SUM_W'(playerY) + sty);
    try_mask[0] = !((c0x == playerX) && (c0y == playerY));
    try_mask[1] = (c0x != playerX);
    try_mask[2] = (c0y != playerY);
  end

  // lowest pending candidate is the next one to query
  always_comb begin
    if (pend[0])      sel = 2'd0;
    else if (pend[1]) sel = 2'd1;
    else              sel = 2'd2;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (tick && moving && (|try_mask)) state_nx = S_QUERY;
      S_QUERY: state_nx = S_CHECK;
      S_CHECK: state_nx = (map_wall && (|pend)) ? S_QUERY : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    map_rd = 1'b0;
    map_x  = '0;
    map_y  = '0;
    busy   = (state != S_IDLE);
    if (state == S_QUERY) begin
      map_rd = 1'b1;
      map_x  = cand_x[sel][POS_W-1:CELL_BITS];
      map_y  = cand_y[sel][POS_W-1:CELL_BITS];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      playerX <= POS_W'(START_X);
      playerY <= POS_W'(START_Y);
      angle   <= ANGLE_W'(START_ANGLE);
      update  <= 1'b0;
      pend    <= '0;
      cur     <= '0;
      for (int i = 0; i < 3; i++) begin
        cand_x[i] <= '0;
        cand_y[i] <= '0;
      end
    end else begin
      update <= 1'b0;
      case (state)
        S_IDLE: if (tick) begin
          if (rot_l) begin
            angle  <= (angle == ANG_LAST) ? '0 : angle + 1'b1;
            update <= 1'b1;
          end else if (rot_r) begin
            angle  <= (angle == '0) ? ANG_LAST : angle - 1'b1;
            update <= 1'b1;
          end
          if (moving) begin
            cand_x[0] <= c0x;     cand_y[0] <= c0y;
            cand_x[1] <= c0x;     cand_y[1] <= playerY;
            cand_x[2] <= playerX; cand_y[2] <= c0y;
            pend      <= try_mask;
          end
        end
        S_QUERY: begin
          cur       <= sel;
          pend[sel] <= 1'b0;
        end
        S_CHECK: if (!map_wall) begin
          playerX <= cand_x[cur];
          playerY <= cand_y[cur];
          update  <= 1'b1;
          pend    <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_player_motion_control.sv
// Bench for player_motion_control: directed and random ticks against a
// per-tick behavioural model with a registered map responder.
module tb_player_motion_control;

  localparam int TD    = 8;
  localparam int STEPS = 320;
  localparam int CELL  = 64;
  localparam int DIVS  = 8;
  localparam int PMAX  = 4095;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic rotate_left = 1'b0, rotate_right = 1'b0, move_forward = 1'b0, move_backward = 1'b0;
  logic signed [9:0] dir_x = '0, dir_y = '0;
  logic map_rd;
  logic [6:0] map_x, map_y;
  logic map_wall = 1'b0;
  logic signed [12:0] playerX, playerY;
  logic [8:0] angle;
  logic busy, update;

  int total = 0, bad = 0, tickn = 0;
  int m_x = 96, m_y = 96, m_a = 80;
  bit walls [0:127][0:127];

  always #5 clock = ~clock;

  player_motion_control #(.TICK_DIV(TD)) dut (
    .clock(clock), .reset(reset),
    .rotate_left(rotate_left), .rotate_right(rotate_right),
    .move_forward(move_forward), .move_backward(move_backward),
    .dir_x(dir_x), .dir_y(dir_y),
    .map_rd(map_rd), .map_x(map_x), .map_y(map_y), .map_wall(map_wall),
    .playerX(playerX), .playerY(playerY), .angle(angle),
    .busy(busy), .update(update)
  );

  // map memory with one-cycle read latency
  always @(posedge clock) map_wall <= map_rd ? walls[map_x][map_y] : 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int fstep(input int d);
    return (d >= 0) ? d / DIVS : -((-d + DIVS - 1) / DIVS);
  endfunction

  function automatic int cl(input int v);
    return (v < 0) ? 0 : (v > PMAX) ? PMAX : v;
  endfunction

  task automatic clear_walls();
    foreach (walls[i, j]) walls[i][j] = 1'b0;
  endtask

  task automatic chk_reset_vals(input string p);
    chk({p, "_x"}, playerX, 96);
    chk({p, "_y"}, playerY, 96);
    chk({p, "_ang"}, angle, 80);
    chk({p, "_upd"}, update, 0);
    chk({p, "_busy"}, busy, 0);
    chk({p, "_rd"}, map_rd, 0);
    chk({p, "_mx"}, map_x, 0);
    chk({p, "_my"}, map_y, 0);
  endtask

  // called at the negedge of a tick cycle; returns at the negedge of the next one
  task automatic do_tick(input bit rl, input bit rr, input bit mf, input bit mb,
                         input int dxi, input int dyi);
    int na, sgn, sx, sy, nq, ck, nx, ny, k;
    bit rot;
    int cx[3], cy[3], qx[3], qy[3];
    string p;
    rotate_left = rl; rotate_right = rr; move_forward = mf; move_backward = mb;
    dir_x = 10'(dxi); dir_y = 10'(dyi);
    na = m_a; rot = 0;
    if (rl && !rr)      begin na = (m_a + 1) % STEPS; rot = 1; end
    else if (rr && !rl) begin na = (m_a + STEPS - 1) % STEPS; rot = 1; end
    sgn = (mf && !mb) ? 1 : (mb && !mf) ? -1 : 0;
    nq = 0; ck = 0; nx = m_x; ny = m_y;
    if (sgn != 0) begin
      sx = sgn * fstep(dxi);
      sy = sgn * fstep(dyi);
      cx = '{cl(m_x + sx), cl(m_x + sx), m_x};
      cy = '{cl(m_y + sy), m_y, cl(m_y + sy)};
      for (int i = 0; i < 3; i++) begin
        if (ck == 0 && !(cx[i] == m_x && cy[i] == m_y)) begin
          qx[nq] = cx[i] / CELL; qy[nq] = cy[i] / CELL; nq++;
          if (!walls[qx[nq-1]][qy[nq-1]]) begin ck = nq; nx = cx[i]; ny = cy[i]; end
        end
      end
    end
    for (int off = 1; off <= 7; off++) begin
      @(negedge clock);
      p = $sformatf("k%0d_o%0d", tickn, off);
      k = (off - 1) / 2;
      chk({p, "_ang"}, angle, na);
      chk({p, "_x"}, playerX, (ck != 0 && off >= 2*ck + 1) ? nx : m_x);
      chk({p, "_y"}, playerY, (ck != 0 && off >= 2*ck + 1) ? ny : m_y);
      chk({p, "_busy"}, busy, (off <= 2*nq) ? 1 : 0);
      chk({p, "_rd"}, map_rd, (off % 2 == 1 && k < nq) ? 1 : 0);
      chk({p, "_mx"}, map_x, (off % 2 == 1 && k < nq) ? qx[k] : 0);
      chk({p, "_my"}, map_y, (off % 2 == 1 && k < nq) ? qy[k] : 0);
      chk({p, "_upd"}, update, ((off == 1 && rot) || (ck != 0 && off == 2*ck + 1)) ? 1 : 0);
    end
    m_a = na; m_x = nx; m_y = ny;
    tickn++;
    @(negedge clock);
  endtask

  task automatic release_and_align();
    reset = 1'b0;
    m_x = 96; m_y = 96; m_a = 80;
    repeat (7) @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    int d;
    clear_walls();
    repeat (3) @(negedge clock);
    chk_reset_vals("rst");
    release_and_align();

    // rotate left for three ticks: 81, 82, 83
    repeat (3) do_tick(1, 0, 0, 0, 0, 0);
    chk("rotl3", angle, 83);

    // walk down to angle 0, then wrap both ways, then both buttons
    for (int i = 0; i < 400 && m_a != 0; i++) do_tick(0, 1, 0, 0, 0, 0);
    do_tick(0, 1, 0, 0, 0, 0);
    chk("wrap_down", angle, 319);
    do_tick(1, 0, 0, 0, 0, 0);
    chk("wrap_up", angle, 0);
    do_tick(1, 1, 0, 0, 0, 0);
    chk("both_rot", angle, 0);

    // open-map forward move
    do_tick(0, 0, 1, 0, 80, -40);
    chk("fwd_x", playerX, 106);
    chk("fwd_y", playerY, 91);

    // reset while the first candidate is being checked
    rotate_left = 0; rotate_right = 0; move_forward = 1; move_backward = 0;
    dir_x = 10'sd80; dir_y = 10'sd40;
    @(negedge clock);
    chk("mid_rd", map_rd, 1);
    @(negedge clock);
    chk("mid_busy", busy, 1);
    #1 reset = 1'b1;
    #1 chk_reset_vals("mid");
    @(negedge clock);
    release_and_align();

    // wall slide: C0 blocked, C1 clear
    walls[1][0] = 1'b1;
    do_tick(0, 0, 1, 0, 80, -320);
    chk("slide_x", playerX, 106);
    chk("slide_y", playerY, 96);
    // every candidate blocked
    walls[1][1] = 1'b1;
    do_tick(0, 0, 1, 0, 80, -320);
    chk("blk_x", playerX, 106);
    clear_walls();

    // travel to (2,4090) for the clamp case
    for (int i = 0; i < 20 && m_x != 2; i++) begin
      d = (2 - m_x < -64) ? -64 : 2 - m_x;
      do_tick(0, 0, 1, 0, d * 8, 0);
    end
    for (int i = 0; i < 100 && m_y != 4090; i++) begin
      d = (4090 - m_y > 63) ? 63 : 4090 - m_y;
      do_tick(0, 0, 1, 0, 0, d * 8);
    end
    do_tick(0, 0, 0, 1, 80, -80);
    chk("clamp_x", playerX, 0);
    chk("clamp_y", playerY, 4095);

    // random walls and buttons
    foreach (walls[i, j]) walls[i][j] = ($urandom_range(0, 99) < 30);
    for (int i = 0; i < 150; i++)
      do_tick($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
              $urandom_range(0, 1), int'($urandom_range(0, 1023)) - 512,
              int'($urandom_range(0, 1023)) - 512);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
